// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU op classes, R-type funct codes,
// forwarding selects and the iterative-multiply sequencer states.
package ex_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_MUL   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_REG2 = 2'b11;

    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf,
                                            input logic [31:0] mem,
                                            input logic [31:0] wb);
        logic [31:0] r;
        r = rf;
        case (sel)
            FWD_REG:  r = rf;
            FWD_MEM:  r = mem;
            FWD_WB:   r = wb;
            FWD_REG2: r = rf;
            default:  r = rf;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier datapath, one multiplier bit per cycle; the caller
// owns the iteration count and signals the final step with last.
module ex_mul_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        last,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic        r_busy;
    logic        r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            // only the low 32 bits are kept, so bits shifted out of r_a are dropped
            if (r_b[0])
                r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
            if (last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// Pipeline EX stage: forwarding muxes, single-cycle ALU, iterative multiply
// sequencer with stall/flush handling, and the EX/MEM pipeline register.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WBReg,
    input  logic [2:0]  MReg,
    input  logic [3:0]  EXReg,
    input  logic [4:0]  RsReg,
    input  logic [4:0]  RtReg,
    input  logic [4:0]  RdReg,
    input  logic [31:0] busAReg,
    input  logic [31:0] busBReg,
    input  logic [31:0] busCReg,
    input  logic [31:0] fwd_mem_data,
    input  logic [31:0] fwd_wb_data,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  WBOut,
    output logic [2:0]  MOut,
    output logic [31:0] ALUOut,
    output logic [31:0] WriteData,
    output logic [4:0]  DstReg,
    output logic        Zero
);

    logic        w_regdst;
    logic [1:0]  w_op;
    logic        w_alusrc;
    logic [5:0]  w_funct;
    logic [31:0] w_opa;
    logic [31:0] w_fwdb;
    logic [31:0] w_opb;
    logic [31:0] w_alu;
    logic [4:0]  w_dst;
    logic        w_unused;

    mul_state_t  r_state;
    mul_state_t  w_next;
    logic [4:0]  r_cnt;
    logic        w_start;
    logic        w_last;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_prod;

    logic [1:0]  r_wb_lat;
    logic [2:0]  r_m_lat;
    logic [4:0]  r_dst_lat;
    logic [31:0] r_wd_lat;

    logic [1:0]  r_wb;
    logic [2:0]  r_m;
    logic [31:0] r_alu;
    logic [31:0] r_wd;
    logic [4:0]  r_dst;
    logic        r_zero;

    assign w_regdst = EXReg[3];
    assign w_op     = EXReg[2:1];
    assign w_alusrc = EXReg[0];
    assign w_funct  = busCReg[5:0];
    assign w_unused = ^RsReg;

    assign w_opa = fwd_mux(fwd_a_sel, busAReg, fwd_mem_data, fwd_wb_data);
    assign w_fwdb = fwd_mux(fwd_b_sel, busBReg, fwd_mem_data, fwd_wb_data);
    assign w_opb = w_alusrc ? busCReg : w_fwdb;
    assign w_dst = w_regdst ? RdReg : RtReg;

    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD: w_alu = w_opa + w_opb;
            ALU_SUB: w_alu = w_opa - w_opb;
            ALU_FUNCT: begin
                case (w_funct)
                    FN_ADD:  w_alu = w_opa + w_opb;
                    FN_SUB:  w_alu = w_opa - w_opb;
                    FN_AND:  w_alu = w_opa & w_opb;
                    FN_OR:   w_alu = w_opa | w_opb;
                    FN_SLT:  w_alu = {31'd0, $signed(w_opa) < $signed(w_opb)};
                    default: w_alu = '0;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    // Multiply sequencer: IDLE latches operands, MUL runs 32 steps, DONE writes back.
    assign w_start = (r_state == ST_IDLE) && (w_op == ALU_MUL) && !flush;
    assign w_last  = (r_cnt == 5'(MUL_ITERS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_op == ALU_MUL) w_next = ST_MUL;
            ST_MUL:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (flush || w_start)
                r_cnt <= '0;
            else if (r_state == ST_MUL)
                r_cnt <= r_cnt + 5'd1;
        end
    end

    ex_mul_iter u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .abort   (flush),
        .last    (w_last),
        .a       (w_opa),
        .b       (w_opb),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_prod)
    );

    // Reset and flush both silence stall so upstream never freezes on a dead op.
    assign stall = rst_n && !flush &&
                   (((r_state == ST_IDLE) && (w_op == ALU_MUL)) ||
                    ((r_state == ST_MUL) && w_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_lat  <= '0;
            r_m_lat   <= '0;
            r_dst_lat <= '0;
            r_wd_lat  <= '0;
        end else if (w_start) begin
            r_wb_lat  <= WBReg;
            r_m_lat   <= MReg;
            r_dst_lat <= w_dst;
            r_wd_lat  <= w_fwdb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb   <= '0;
            r_m    <= '0;
            r_alu  <= '0;
            r_wd   <= '0;
            r_dst  <= '0;
            r_zero <= 1'b0;
        end else if (flush) begin
            r_wb <= '0;
            r_m  <= '0;
        end else if ((r_state == ST_DONE) && w_done) begin
            r_wb   <= r_wb_lat;
            r_m    <= r_m_lat;
            r_alu  <= w_prod;
            r_wd   <= r_wd_lat;
            r_dst  <= r_dst_lat;
            r_zero <= (w_prod == 32'd0);
        end else if (stall) begin
            r_wb <= '0;
            r_m  <= '0;
        end else begin
            r_wb   <= WBReg;
            r_m    <= MReg;
            r_alu  <= w_alu;
            r_wd   <= w_fwdb;
            r_dst  <= w_dst;
            r_zero <= (w_alu == 32'd0);
        end
    end

    assign WBOut     = r_wb;
    assign MOut      = r_m;
    assign ALUOut    = r_alu;
    assign WriteData = r_wd;
    assign DstReg    = r_dst;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table, randomized ALU/multiply
// against a reference model, plus stall, flush and reset sequences.
module tb_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  WBReg;
    logic [2:0]  MReg;
    logic [3:0]  EXReg;
    logic [4:0]  RsReg, RtReg, RdReg;
    logic [31:0] busAReg, busBReg, busCReg;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        flush;
    logic        stall;
    logic [1:0]  WBOut;
    logic [2:0]  MOut;
    logic [31:0] ALUOut, WriteData;
    logic [4:0]  DstReg;
    logic        Zero;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .WBReg(WBReg), .MReg(MReg), .EXReg(EXReg),
        .RsReg(RsReg), .RtReg(RtReg), .RdReg(RdReg),
        .busAReg(busAReg), .busBReg(busBReg), .busCReg(busCReg),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .flush(flush),
        .stall(stall), .WBOut(WBOut), .MOut(MOut), .ALUOut(ALUOut),
        .WriteData(WriteData), .DstReg(DstReg), .Zero(Zero)
    );

    typedef struct {
        logic [3:0]  ex;
        logic [1:0]  fa, fb;
        logic [31:0] a, b, c, mem, wbd;
        logic [31:0] e_alu, e_wd;
        logic        e_z;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_alu;

    function automatic logic [31:0] ref_fwd(input logic [1:0] s, input logic [31:0] r, m, w);
        if (s == 2'b01) return m;
        if (s == 2'b10) return w;
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, b);
        longint unsigned p;
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: begin p = longint'(a) * longint'(b); return p[31:0]; end
            default: begin
                if (fn == 6'h20) return a + b;
                if (fn == 6'h22) return a - b;
                if (fn == 6'h24) return a & b;
                if (fn == 6'h25) return a | b;
                if (fn == 6'h2A) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [1:0] wb, input logic [2:0] m,
                             input logic [31:0] alu, wd, input logic [4:0] dst, input logic z);
        chk({nm, ".wb"}, 32'(WBOut), 32'(wb));
        chk({nm, ".m"}, 32'(MOut), 32'(m));
        chk({nm, ".alu"}, ALUOut, alu);
        chk({nm, ".wd"}, WriteData, wd);
        chk({nm, ".dst"}, 32'(DstReg), 32'(dst));
        chk({nm, ".zero"}, 32'(Zero), 32'(z));
    endtask

    task automatic drive(input logic [3:0] ex, input logic [1:0] fa, fb,
                         input logic [31:0] a, b, c, mem, wbd,
                         input logic [1:0] wb, input logic [2:0] m, input logic [4:0] rt, rd);
        EXReg = ex; fwd_a_sel = fa; fwd_b_sel = fb;
        busAReg = a; busBReg = b; busCReg = c;
        fwd_mem_data = mem; fwd_wb_data = wbd;
        WBReg = wb; MReg = m; RtReg = rt; RdReg = rd; RsReg = 5'd31;
    endtask

    task automatic nop();
        drive(4'b0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, 5'd0);
    endtask

    // Counts stall cycles; forwarding inputs are scrambled once the operands are taken.
    task automatic wait_stall(output int cnt, output logic ok);
        cnt = 0; ok = 1'b1;
        #1;
        while (stall && cnt < 100) begin
            @(posedge clk); @(negedge clk);
            cnt++;
            if (WBOut !== 2'b00 || MOut !== 3'b000) ok = 1'b0;
            fwd_mem_data = $urandom; fwd_wb_data = $urandom;
            fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom);
        end
    endtask

    task automatic mul_test(input string nm, input logic [31:0] a, b,
                            input logic [1:0] fa, fb, input logic [31:0] mem, wbd,
                            input logic regdst, input logic [31:0] exp);
        int   cnt;
        logic ok;
        drive({regdst, 2'b11, 1'b0}, fa, fb, a, b, 32'h0, mem, wbd, 2'b11, 3'b101, 5'd3, 5'd9);
        wait_stall(cnt, ok);
        chk({nm, ".stallcnt"}, 32'(cnt), 32'd33);
        chk({nm, ".bubble"}, 32'(ok), 32'd1);
        nop();
        @(posedge clk); @(negedge clk);
        check_out(nm, 2'b11, 3'b101, exp, ref_fwd(fb, b, mem, wbd), regdst ? 5'd9 : 5'd3, exp == 0);
        last_alu = exp;
    endtask

    vec_t tv[14];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          cnt;
        logic        ok;
        logic [31:0] ra, rb, rc, rm, rw, ea, efb, eb, er, rnd;
        logic [1:0]  op, fa, fb;
        logic        src, rdst;
        logic [5:0]  fns[6];

        tv[0]  = '{4'b0000, 2'b00, 2'b00, 32'd7, 32'd5, 32'd0, 32'd0, 32'd0, 32'd12, 32'd5, 1'b0};
        tv[1]  = '{4'b0010, 2'b00, 2'b00, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1};
        tv[2]  = '{4'b1100, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'd0, 32'd0, 32'd1, 32'd1, 1'b0};
        tv[3]  = '{4'b1100, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'h3F, 32'd0, 32'd0, 32'd0, 32'd1, 1'b1};
        tv[4]  = '{4'b1100, 2'b01, 2'b00, 32'd0, 32'd3, 32'h20, 32'd100, 32'd0, 32'd103, 32'd3, 1'b0};
        tv[5]  = '{4'b1100, 2'b00, 2'b10, 32'd1, 32'd5, 32'h20, 32'd0, 32'hDEADBEEF, 32'hDEADBEF0, 32'hDEADBEEF, 1'b0};
        tv[6]  = '{4'b1100, 2'b00, 2'b00, 32'hF0F0, 32'hFF00, 32'h24, 32'd0, 32'd0, 32'hF000, 32'hFF00, 1'b0};
        tv[7]  = '{4'b1100, 2'b00, 2'b00, 32'h0F, 32'hF0, 32'h25, 32'd0, 32'd0, 32'hFF, 32'hF0, 1'b0};
        tv[8]  = '{4'b0001, 2'b00, 2'b00, 32'd10, 32'd77, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd9, 32'd77, 1'b0};
        tv[9]  = '{4'b0010, 2'b00, 2'b00, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 1'b0};
        tv[10] = '{4'b0000, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 1'b1};
        tv[11] = '{4'b1100, 2'b00, 2'b00, 32'd1, 32'hFFFFFFFF, 32'h2A, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1};
        tv[12] = '{4'b0000, 2'b11, 2'b00, 32'd5, 32'd6, 32'd0, 32'd100, 32'd0, 32'd11, 32'd6, 1'b0};
        tv[13] = '{4'b1100, 2'b00, 2'b00, 32'd10, 32'd3, 32'h22, 32'd0, 32'd0, 32'd7, 32'd3, 1'b0};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

        rst_n = 1'b0; flush = 1'b0;
        nop();
        repeat (3) @(negedge clk);
        check_out("reset", 2'b00, 3'b000, 0, 0, 5'd0, 1'b0);
        chk("reset.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tv[i].ex, tv[i].fa, tv[i].fb, tv[i].a, tv[i].b, tv[i].c, tv[i].mem, tv[i].wbd,
                  2'b01 | 2'(i), 3'b100 | 3'(i), 5'(i), 5'(i + 8));
            @(posedge clk); @(negedge clk);
            check_out($sformatf("tv%0d", i), 2'b01 | 2'(i), 3'b100 | 3'(i), tv[i].e_alu, tv[i].e_wd,
                      tv[i].ex[3] ? 5'(i + 8) : 5'(i), tv[i].e_z);
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 2)); fa = 2'($urandom); fb = 2'($urandom);
            src = 1'($urandom); rdst = 1'($urandom);
            ra = $urandom; rb = $urandom; rm = $urandom; rw = $urandom; rnd = $urandom;
            if (i % 4 == 0) rb = ra;
            rc = {rnd[31:6], fns[$urandom_range(0, 5)]};
            ea = ref_fwd(fa, ra, rm, rw); efb = ref_fwd(fb, rb, rm, rw);
            eb = src ? rc : efb;
            er = ref_alu(op, rc[5:0], ea, eb);
            drive({rdst, op, src}, fa, fb, ra, rb, rc, rm, rw, 2'b10, 3'b011, 5'd12, 5'd21);
            @(posedge clk); @(negedge clk);
            check_out($sformatf("rnd%0d", i), 2'b10, 3'b011, er, efb, rdst ? 5'd21 : 5'd12, er == 0);
        end

        mul_test("mul1234", 32'd1234, 32'd5678, 2'b00, 2'b00, 0, 0, 1'b1, 32'd7006652);

        // back-to-back multiplies: second enters EX right after DONE
        drive(4'b1110, 2'b00, 2'b00, 32'h10000, 32'h10000, 0, 0, 0, 2'b10, 3'b010, 5'd4, 5'd5);
        wait_stall(cnt, ok);
        chk("chain1.stallcnt", 32'(cnt), 32'd33);
        drive(4'b0110, 2'b00, 2'b00, 32'd3, 32'd7, 0, 0, 0, 2'b01, 3'b001, 5'd6, 5'd7);
        @(posedge clk); @(negedge clk);
        check_out("chain1", 2'b10, 3'b010, 0, 32'h10000, 5'd5, 1'b1);
        #1 chk("chain2.restart", 32'(stall), 32'd1);
        wait_stall(cnt, ok);
        chk("chain2.stallcnt", 32'(cnt), 32'd33);
        chk("chain2.bubble", 32'(ok), 32'd1);
        nop();
        @(posedge clk); @(negedge clk);
        check_out("chain2", 2'b01, 3'b001, 32'd21, 32'd7, 5'd6, 1'b0);
        last_alu = 32'd21;

        for (int i = 0; i < 3; i++) begin
            fa = 2'($urandom); fb = 2'($urandom);
            ra = $urandom; rb = $urandom; rm = $urandom; rw = $urandom;
            er = ref_alu(2'b11, 6'h0, ref_fwd(fa, ra, rm, rw), ref_fwd(fb, rb, rm, rw));
            mul_test($sformatf("rmul%0d", i), ra, rb, fa, fb, rm, rw, 1'($urandom), er);
        end

        // flush wins over the DONE writeback
        drive(4'b0110, 2'b00, 2'b00, 32'd9, 32'd9, 0, 0, 0, 2'b11, 3'b111, 5'd1, 5'd2);
        wait_stall(cnt, ok);
        flush = 1'b1; nop();
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        chk("flushdone.wb", 32'(WBOut), 32'd0);
        chk("flushdone.m", 32'(MOut), 32'd0);
        chk("flushdone.alu", ALUOut, last_alu);

        // flush during iteration 10
        drive(4'b0110, 2'b00, 2'b00, 32'd77, 32'd88, 0, 0, 0, 2'b11, 3'b111, 5'd1, 5'd2);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        chk("flushmid.wb", 32'(WBOut), 32'd0);
        chk("flushmid.m", 32'(MOut), 32'd0);
        chk("flushmid.alu", ALUOut, last_alu);
        drive(4'b0000, 2'b00, 2'b00, 32'd20, 32'd22, 0, 0, 0, 2'b11, 3'b110, 5'd10, 5'd11);
        #1 chk("flushmid.stall", 32'(stall), 32'd0);
        @(posedge clk); @(negedge clk);
        check_out("postflush", 2'b11, 3'b110, 32'd42, 32'd22, 5'd10, 1'b0);

        // flush on a plain ALU op
        drive(4'b0000, 2'b00, 2'b00, 32'd1, 32'd1, 0, 0, 0, 2'b11, 3'b111, 5'd3, 5'd4);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check_out("flushadd", 2'b00, 3'b000, 32'd42, 32'd22, 5'd10, 1'b0);

        // reset in the middle of a multiply
        drive(4'b0110, 2'b00, 2'b00, 32'd1234, 32'd5678, 0, 0, 0, 2'b11, 3'b101, 5'd3, 5'd9);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_out("rstmul", 2'b00, 3'b000, 0, 0, 5'd0, 1'b0);
        chk("rstmul.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mul_test("postrst", 32'd1234, 32'd5678, 2'b00, 2'b00, 0, 0, 1'b0, 32'd7006652);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
